// File: rtl/up_packet_master.sv
`default_nettype none
// up_packet_master: byte-wide uP handshake bus master. Sends a CMD_BYTES command packet,
// collects a REPLY_BYTES reply, with per-phase timeouts and abort recovery.
module up_packet_master #(
    parameter int CMD_BYTES      = 6,
    parameter int REPLY_BYTES    = 8,
    parameter int SETUP_CYCLES   = 2,
    parameter int START_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [8*CMD_BYTES-1:0]   cmd_packet,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic [8*REPLY_BYTES-1:0] reply_packet,
    output logic                     uP_start,
    output logic                     uP_handshake_1,
    output logic                     uP_RW,
    output logic [7:0]               uP_data_out,
    output logic                     uP_data_oe,
    input  logic [7:0]               uP_data_in,
    input  logic                     uP_handshake_2,
    input  logic                     uP_ack
);
    localparam int MAX_BYTES = (CMD_BYTES > REPLY_BYTES) ? CMD_BYTES : REPLY_BYTES;
    localparam int IW        = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [IW-1:0] LAST_CMD   = IW'(CMD_BYTES - 1);
    localparam logic [IW-1:0] LAST_REPLY = IW'(REPLY_BYTES - 1);
    localparam logic [31:0]   START_LAST = 32'(START_CYCLES - 1);
    localparam logic [31:0]   SETUP_LAST = 32'(SETUP_CYCLES - 1);
    localparam logic [31:0]   TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam bit            TMO_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_W_SETUP, S_W_HS1, S_W_REL, S_R_WAIT,
        S_R_SETUP, S_R_ACK, S_R_REL, S_END, S_DONE, S_ABORT
    } state_t;

    state_t                   state, state_d;
    logic [31:0]              cnt, cnt_d;
    logic [IW-1:0]            idx, idx_d;
    logic [8*CMD_BYTES-1:0]   cmd_lat, cmd_d;
    logic [8*REPLY_BYTES-1:0] reply_d;
    logic [1:0]               hs2_sync, ack_sync;
    logic                     hs2, ack, timed_out;
    logic                     start_d, hs1_d, rw_d, busy_d, done_d, terr_d;
    logic [7:0]               data_d;

    assign hs2        = hs2_sync[1];
    assign ack        = ack_sync[1];
    assign uP_data_oe = uP_RW;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs2_sync <= '0;
            ack_sync <= '0;
        end else begin
            hs2_sync <= {hs2_sync[0], uP_handshake_2};
            ack_sync <= {ack_sync[0], uP_ack};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            cmd_lat        <= '0;
            reply_packet   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
            uP_start       <= 1'b0;
            uP_handshake_1 <= 1'b0;
            uP_RW          <= 1'b0;
            uP_data_out    <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            idx            <= idx_d;
            cmd_lat        <= cmd_d;
            reply_packet   <= reply_d;
            busy           <= busy_d;
            done           <= done_d;
            timeout_err    <= terr_d;
            uP_start       <= start_d;
            uP_handshake_1 <= hs1_d;
            uP_RW          <= rw_d;
            uP_data_out    <= data_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 32'd1;
        idx_d     = idx;
        cmd_d     = cmd_lat;
        reply_d   = reply_packet;
        timed_out = TMO_EN && (cnt == TMO_LAST);
        case (state)
            S_IDLE: if (req) begin
                state_d = S_START;
                cmd_d   = cmd_packet;
                reply_d = '0;
                idx_d   = '0;
            end
            S_START:   if (cnt == START_LAST) state_d = S_W_SETUP;
            S_W_SETUP: if (cnt == SETUP_LAST) state_d = S_W_HS1;
            S_W_HS1: begin
                if (hs2)            state_d = S_W_REL;
                else if (timed_out) state_d = S_ABORT;
            end
            S_W_REL: begin
                if (!hs2) begin
                    if (idx == LAST_CMD) begin
                        idx_d   = '0;
                        state_d = S_R_WAIT;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = S_W_SETUP;
                    end
                end else if (timed_out) begin
                    state_d = S_ABORT;
                end
            end
            S_R_WAIT: begin
                if (hs2)            state_d = S_R_SETUP;
                else if (timed_out) state_d = S_ABORT;
            end
            S_R_SETUP: if (cnt == SETUP_LAST) begin
                for (int i = 0; i < REPLY_BYTES; i++)
                    if (idx == IW'(i)) reply_d[8*i +: 8] = uP_data_in;
                state_d = S_R_ACK;
            end
            S_R_ACK: begin
                if (!hs2)           state_d = S_R_REL;
                else if (timed_out) state_d = S_ABORT;
            end
            S_R_REL: begin
                if (idx == LAST_REPLY) begin
                    state_d = S_END;
                end else begin
                    idx_d   = idx + 1'b1;
                    state_d = S_R_WAIT;
                end
            end
            S_END: begin
                if (ack)            state_d = S_DONE;
                else if (timed_out) state_d = S_ABORT;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state) cnt_d = '0;

        // Outputs are registered from the next state; RW is held one extra cycle
        // after handshake_1 falls so data/RW outlive the strobe.
        start_d = (state_d == S_START);
        hs1_d   = (state_d == S_W_HS1) || (state_d == S_R_ACK);
        rw_d    = (state_d == S_W_SETUP) || (state_d == S_W_HS1) ||
                  ((state_d == S_W_REL) && (state == S_W_HS1));
        data_d  = '0;
        if (rw_d)
            for (int i = 0; i < CMD_BYTES; i++)
                if (idx_d == IW'(i)) data_d = cmd_lat[8*i +: 8];
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        terr_d  = (state_d == S_DONE) && (state == S_ABORT);
    end
endmodule
`default_nettype wire

// File: tb/tb_up_packet_master.sv
`default_nettype none
// tb_up_packet_master: randomized bench with a behavioural bus slave and packet-level
// reference model, exercising two parameter builds of up_packet_master.
module tb_up_packet_master;
    localparam int TMO0 = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [47:0] cmd0 = '0;
    logic [15:0] cmd1 = '0;
    logic        s_hs2 = 1'b0, s_ack = 1'b0;
    logic [7:0]  s_din = '0;
    logic        sel = 1'b0;

    logic        busy0, done0, terr0, start0, hs1_0, rw0, oe0;
    logic [7:0]  dout0;
    logic [63:0] reply0;
    logic        busy1, done1, terr1, start1, hs1_1, rw1, oe1;
    logic [7:0]  dout1;
    logic [23:0] reply1;

    up_packet_master #(.CMD_BYTES(6), .REPLY_BYTES(8), .SETUP_CYCLES(2),
                       .START_CYCLES(4), .TIMEOUT_CYCLES(TMO0)) u0 (
        .clk(clk), .reset(reset), .req(req0), .cmd_packet(cmd0),
        .busy(busy0), .done(done0), .timeout_err(terr0), .reply_packet(reply0),
        .uP_start(start0), .uP_handshake_1(hs1_0), .uP_RW(rw0),
        .uP_data_out(dout0), .uP_data_oe(oe0), .uP_data_in(s_din),
        .uP_handshake_2(s_hs2), .uP_ack(s_ack));

    up_packet_master #(.CMD_BYTES(2), .REPLY_BYTES(3), .SETUP_CYCLES(3),
                       .START_CYCLES(2), .TIMEOUT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .req(req1), .cmd_packet(cmd1),
        .busy(busy1), .done(done1), .timeout_err(terr1), .reply_packet(reply1),
        .uP_start(start1), .uP_handshake_1(hs1_1), .uP_RW(rw1),
        .uP_data_out(dout1), .uP_data_oe(oe1), .uP_data_in(s_din),
        .uP_handshake_2(s_hs2), .uP_ack(s_ack));

    logic       m_start, m_hs1, m_rw, m_oe, m_done, m_busy;
    logic [7:0] m_dout;
    assign m_start = sel ? start1 : start0;
    assign m_hs1   = sel ? hs1_1  : hs1_0;
    assign m_rw    = sel ? rw1    : rw0;
    assign m_oe    = sel ? oe1    : oe0;
    assign m_done  = sel ? done1  : done0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_dout  = sel ? dout1  : dout0;

    int checks = 0, failures = 0;
    int done_cnt0 = 0, err_cnt0 = 0, done_cnt1 = 0, err_cnt1 = 0;
    int wr_hs1 = 0, rd_hs1 = 0, rw_bad = 0, start_w = 0;
    logic hs1_1_q = 1'b0;
    logic [7:0] slog[$];
    logic [7:0] rbytes[16];

    always @(posedge clk) begin
        if (done0) begin done_cnt0 <= done_cnt0 + 1; if (terr0) err_cnt0 <= err_cnt0 + 1; end
        if (done1) begin done_cnt1 <= done_cnt1 + 1; if (terr1) err_cnt1 <= err_cnt1 + 1; end
        if (hs1_1 && !hs1_1_q) begin
            if (rw1) wr_hs1 <= wr_hs1 + 1;
            else     rd_hs1 <= rd_hs1 + 1;
        end
        hs1_1_q <= hs1_1;
    end

    // Reference model: packets are plain byte arrays, byte 0 in the low bits.
    function automatic logic [127:0] exp_reply(input int n);
        logic [127:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = rbytes[i];
        return r;
    endfunction

    function automatic logic [127:0] got_log();
        logic [127:0] r = '0;
        foreach (slog[i]) if (i < 16) r[8*i +: 8] = slog[i];
        return r;
    endfunction

    function automatic logic cur(input int which);
        case (which)
            0:       return m_start;
            1:       return m_hs1;
            default: return m_done;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic v, input int budget, output bit ok);
        int n = 0;
        while (cur(which) !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (cur(which) === v);
        if (!ok) begin
            checks++; failures++;
            $display("FAIL wait_sig%0d: stayed %b, required %b within %0d cycles", which, cur(which), v, budget);
        end
    endtask

    task automatic kick();
        @(negedge clk);
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic fill_reply(input int n);
        for (int i = 0; i < 16; i++) rbytes[i] = (i < n) ? 8'($urandom) : 8'h00;
    endtask

    // Behavioural slave. stall_w: write byte whose hs1 is never answered;
    // rack_stop: read byte at which the slave stops after seeing hs1 (master in R_ACK).
    task automatic run_slave(input int ncmd, input int nrep, input int dly,
                             input int stall_w, input int rack_stop, output bit ok);
        slog.delete();
        start_w = 0;
        wait_for(0, 1'b1, 400, ok); if (!ok) return;
        while (m_start === 1'b1 && start_w < 100) begin start_w++; @(negedge clk); end
        for (int b = 0; b < ncmd; b++) begin
            wait_for(1, 1'b1, 200, ok); if (!ok) return;
            slog.push_back(m_dout);
            if (m_rw !== 1'b1 || m_oe !== 1'b1) rw_bad++;
            if (b == stall_w) return;
            repeat (dly) @(negedge clk);
            s_hs2 = 1'b1;
            wait_for(1, 1'b0, 200, ok); if (!ok) return;
            repeat (dly) @(negedge clk);
            s_hs2 = 1'b0;
        end
        for (int b = 0; b < nrep; b++) begin
            repeat (dly + 1) @(negedge clk);
            s_din = rbytes[b];
            s_hs2 = 1'b1;
            wait_for(1, 1'b1, 200, ok); if (!ok) return;
            if (m_rw !== 1'b0 || m_oe !== 1'b0) rw_bad++;
            if (b == rack_stop) return;
            s_din = 8'($urandom);
            repeat (dly) @(negedge clk);
            s_hs2 = 1'b0;
            wait_for(1, 1'b0, 200, ok); if (!ok) return;
        end
        repeat (dly) @(negedge clk);
        s_ack = 1'b1;
        wait_for(2, 1'b1, 200, ok);
        s_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, terr0, start0, hs1_0, rw0, oe0, dout0, reply0} !== '0) begin
            failures++; $display("FAIL reset_u0: outputs %h, required 0", {busy0, done0, terr0, start0, hs1_0, rw0, oe0, dout0, reply0});
        end
        checks++;
        if ({busy1, done1, terr1, start1, hs1_1, rw1, oe1, dout1, reply1} !== '0) begin
            failures++; $display("FAIL reset_u1: outputs %h, required 0", {busy1, done1, terr1, start1, hs1_1, rw1, oe1, dout1, reply1});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, start0, hs1_0, rw0} !== '0) begin
            failures++; $display("FAIL idle_after_reset: %b, required 0", {busy0, done0, start0, hs1_0, rw0});
        end
    endtask

    task automatic test_pwm();
        bit ok;
        int d0, e0;
        logic [7:0] pwm;
        sel = 1'b0;
        pwm = 8'($urandom_range(1, 255));
        cmd0 = {8'h00, 8'h00, 8'h00, 8'h64, pwm, 8'h01};
        fill_reply(0);
        rbytes[0] = 8'h64;
        d0 = done_cnt0; e0 = err_cnt0; rw_bad = 0;
        kick();
        checks++;
        if ({busy0, start0} !== 2'b11) begin
            failures++; $display("FAIL accept_latency: busy,start=%b required 11", {busy0, start0});
        end
        run_slave(6, 8, 1, -1, -1, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (slog.size() != 6) begin failures++; $display("FAIL pwm_count: %0d bytes, required 6", slog.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_log()[8*i +: 8] !== cmd0[8*i +: 8]) begin
                failures++; $display("FAIL pwm_byte%0d: got %h required %h", i, got_log()[8*i +: 8], cmd0[8*i +: 8]);
            end
        end
        checks++;
        if (reply0[31:0] !== 32'h0000_0064) begin failures++; $display("FAIL pwm_reply: got %h required 00000064", reply0[31:0]); end
        checks++;
        if (done_cnt0 - d0 != 1 || err_cnt0 != e0) begin
            failures++; $display("FAIL pwm_done: %0d done %0d err, required 1 done 0 err", done_cnt0 - d0, err_cnt0 - e0);
        end
        checks++;
        if (start_w != 4) begin failures++; $display("FAIL start_width: %0d cycles, required 4", start_w); end
        checks++;
        if (rw_bad != 0) begin failures++; $display("FAIL rw_level: %0d bad handshakes, required 0", rw_bad); end
    endtask

    task automatic test_random();
        bit ok;
        int d0, e0, dly;
        logic [127:0] er;
        sel = 1'b0;
        for (int t = 0; t < 4; t++) begin
            cmd0 = {16'($urandom), 32'($urandom)};
            fill_reply(8);
            er = exp_reply(8);
            dly = $urandom_range(0, 8);
            d0 = done_cnt0; e0 = err_cnt0; rw_bad = 0;
            kick();
            run_slave(6, 8, dly, -1, -1, ok);
            repeat (2) @(negedge clk);
            checks++;
            if (slog.size() != 6 || got_log()[47:0] !== cmd0) begin
                failures++; $display("FAIL rand%0d_cmd: got %h (%0d bytes) required %h", t, got_log()[47:0], slog.size(), cmd0);
            end
            checks++;
            if (reply0 !== er[63:0]) begin failures++; $display("FAIL rand%0d_reply: got %h required %h", t, reply0, er[63:0]); end
            checks++;
            if (done_cnt0 - d0 != 1 || err_cnt0 != e0 || rw_bad != 0) begin
                failures++; $display("FAIL rand%0d_done: done %0d err %0d rwbad %0d, required 1 0 0", t, done_cnt0 - d0, err_cnt0 - e0, rw_bad);
            end
        end
    endtask

    task automatic test_param();
        bit ok;
        int w0, r0, d1;
        logic [127:0] er;
        sel = 1'b1;
        cmd1 = 16'($urandom);
        fill_reply(3);
        er = exp_reply(3);
        w0 = wr_hs1; r0 = rd_hs1; d1 = done_cnt1;
        kick();
        run_slave(2, 3, 0, -1, -1, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_hs1 - w0 != 2 || rd_hs1 - r0 != 3) begin
            failures++; $display("FAIL param_handshakes: %0d writes %0d reads, required 2 3", wr_hs1 - w0, rd_hs1 - r0);
        end
        checks++;
        if (reply1 !== er[23:0]) begin failures++; $display("FAIL param_reply: got %h required %h", reply1, er[23:0]); end
        checks++;
        if (got_log()[15:0] !== cmd1 || done_cnt1 - d1 != 1) begin
            failures++; $display("FAIL param_cmd: got %h done %0d, required %h done 1", got_log()[15:0], done_cnt1 - d1, cmd1);
        end
        checks++;
        if (start_w != 2) begin failures++; $display("FAIL param_start_width: %0d, required 2", start_w); end
    endtask

    task automatic test_long_delay();
        bit ok;
        int d1, e1;
        logic [127:0] er;
        sel = 1'b1;
        cmd1 = 16'($urandom);
        fill_reply(3);
        er = exp_reply(3);
        d1 = done_cnt1; e1 = err_cnt1;
        kick();
        run_slave(2, 3, 40, -1, -1, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt1 - d1 != 1 || err_cnt1 != e1) begin
            failures++; $display("FAIL slow_done: done %0d err %0d, required 1 0", done_cnt1 - d1, err_cnt1 - e1);
        end
        checks++;
        if (reply1 !== er[23:0] || got_log()[15:0] !== cmd1) begin
            failures++; $display("FAIL slow_data: reply %h cmd %h, required %h %h", reply1, got_log()[15:0], er[23:0], cmd1);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        sel = 1'b0;
        cmd0 = {16'($urandom), 32'($urandom)};
        fill_reply(8);
        kick();
        run_slave(6, 8, 0, 2, -1, ok);
        n = 0;
        while (hs1_0 === 1'b1 && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (n != TMO0) begin failures++; $display("FAIL timeout_len: hs1 high %0d cycles, required %0d", n, TMO0); end
        checks++;
        if ({start0, hs1_0, rw0, oe0, dout0, done0} !== '0) begin
            failures++; $display("FAIL abort_bus: %h, required 0", {start0, hs1_0, rw0, oe0, dout0, done0});
        end
        @(negedge clk);
        checks++;
        if ({done0, terr0} !== 2'b11) begin failures++; $display("FAIL abort_done: done,err=%b required 11", {done0, terr0}); end
        checks++;
        if (reply0 !== '0 || slog.size() != 3 || got_log()[23:0] !== cmd0[23:0]) begin
            failures++; $display("FAIL abort_data: reply %h log %h (%0d), required 0 %h (3)", reply0, got_log()[23:0], slog.size(), cmd0[23:0]);
        end
        @(negedge clk);
        checks++;
        if ({busy0, done0} !== 2'b00) begin failures++; $display("FAIL abort_idle: busy,done=%b required 00", {busy0, done0}); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        logic [47:0] cmd_b;
        logic [127:0] ea, eb;
        sel = 1'b0;
        d0 = done_cnt0;
        cmd0 = {16'($urandom), 32'($urandom)};
        fill_reply(8);
        ea = exp_reply(8);
        @(negedge clk);
        req0 = 1'b1;
        run_slave(6, 8, 1, -1, -1, ok);
        checks++;
        if (got_log()[47:0] !== cmd0 || reply0 !== ea[63:0]) begin
            failures++; $display("FAIL b2b_first: cmd %h reply %h, required %h %h", got_log()[47:0], reply0, cmd0, ea[63:0]);
        end
        cmd_b = {16'($urandom), 32'($urandom)};
        cmd0 = cmd_b;
        fill_reply(8);
        eb = exp_reply(8);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin failures++; $display("FAIL b2b_gap_idle: busy=%b required 0", busy0); end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin failures++; $display("FAIL b2b_gap_accept: busy=%b required 1", busy0); end
        req0 = 1'b0;
        fork
            run_slave(6, 8, 1, -1, -1, ok);
            begin
                repeat (10) @(negedge clk);
                cmd0 = ~cmd_b;
                req0 = 1'b1; @(negedge clk); req0 = 1'b0;
                repeat (15) @(negedge clk);
                req0 = 1'b1; @(negedge clk); req0 = 1'b0;
            end
        join
        checks++;
        if (got_log()[47:0] !== cmd_b || reply0 !== eb[63:0]) begin
            failures++; $display("FAIL b2b_second: cmd %h reply %h, required %h %h", got_log()[47:0], reply0, cmd_b, eb[63:0]);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done_cnt0 - d0 != 2) begin
            failures++; $display("FAIL b2b_ignored_req: busy %b done %0d, required 0 2", busy0, done_cnt0 - d0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        logic [127:0] er;
        sel = 1'b0;
        cmd0 = {16'($urandom), 32'($urandom)};
        fill_reply(8);
        kick();
        run_slave(6, 8, 0, -1, 1, ok);
        d0 = done_cnt0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({hs1_0, start0, rw0, oe0, busy0, done0} !== '0) begin
            failures++; $display("FAIL async_reset: hs1,start,rw,oe,busy,done=%b required 0", {hs1_0, start0, rw0, oe0, busy0, done0});
        end
        s_hs2 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (reply0 !== '0 || done_cnt0 != d0) begin
            failures++; $display("FAIL reset_no_done: reply %h done %0d, required 0 0", reply0, done_cnt0 - d0);
        end
        cmd0 = {16'($urandom), 32'($urandom)};
        fill_reply(8);
        er = exp_reply(8);
        kick();
        run_slave(6, 8, 2, -1, -1, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (reply0 !== er[63:0] || got_log()[47:0] !== cmd0 || done_cnt0 - d0 != 1) begin
            failures++; $display("FAIL post_reset_txn: reply %h cmd %h done %0d, required %h %h 1", reply0, got_log()[47:0], done_cnt0 - d0, er[63:0], cmd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pwm();
        test_random();
        test_param();
        test_long_delay();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/up_packet_master.md
# uP_packet_master

Synthesisable, parametrised master for the byte-wide uP handshake bus (start / handshake_1 / handshake_2 / RW / ack / 8-bit data). It sends an N-byte command packet and collects an M-byte reply, replacing the fixed 6-out/8-in bench tasks with hardware. It sits in a self-test or loopback wrapper beside `motion_system`, or behind a soft processor, driving the slave side of the same protocol. Unlike the bench tasks, it adds per-phase timeouts and abort recovery.

## Interface
- `CMD_BYTES`, 6, command bytes sent per transaction (1..16)
- `REPLY_BYTES`, 8, reply bytes read per transaction (1..16)
- `SETUP_CYCLES`, 2, cycles data/RW is held stable before a handshake_1 edge (>=1)
- `START_CYCLES`, 4, cycles `uP_start` is held high at transaction start (>=1)
- `TIMEOUT_CYCLES`, 1000, maximum cycles in any wait state; 0 disables the timeout
- `clk` in 1: system clock
- `reset` in 1: reset, asynchronous, active-low
- `req` in 1: start a transaction; sampled only in IDLE
- `cmd_packet` in 8*CMD_BYTES: byte i is `[8i+7:8i]`; byte 0 is sent first; latched on accept
- `busy` out 1: high from accept until the `done` cycle inclusive
- `done` out 1: one-cycle pulse at the end of a transaction
- `timeout_err` out 1: valid with `done`; 1 means the transaction was aborted
- `reply_packet` out 8*REPLY_BYTES: byte i at `[8i+7:8i]`; byte 0 is received first
- `uP_start`, `uP_handshake_1`, `uP_RW` out 1 each: bus control, all registered
- `uP_data_out` out 8; `uP_data_oe` out 1 (equals `uP_RW`; the top level builds the tri-state)
- `uP_data_in` in 8: bus read data
- `uP_handshake_2`, `uP_ack` in 1 each: asynchronous; each passes through a 2-FF synchroniser

## Operation
- Reset values: all outputs 0; `reply_packet` 0; state IDLE.
- IDLE: on `req`=1, latch `cmd_packet`, clear `reply_packet`, set byte count to 0, and go to START.
- START: `uP_start`=1 for START_CYCLES, then `uP_start`=0 and go to W_SETUP.
- W_SETUP: drive `uP_data_out` with the current command byte, `uP_RW`=1, for SETUP_CYCLES, then go to W_HS1.
- W_HS1: `uP_handshake_1`=1; wait for synced hs2=1, then go to W_REL.
- W_REL: `uP_handshake_1`=0, `uP_RW`=0; wait for synced hs2=0. Then increment the byte count and go to W_SETUP, or, after the last command byte, clear the count and go to R_WAIT.
- R_WAIT: `uP_RW`=0; wait for synced hs2=1, then go to R_SETUP.
- R_SETUP: wait SETUP_CYCLES, then capture `uP_data_in` into the reply byte at the current count and go to R_ACK.
- R_ACK: `uP_handshake_1`=1; wait for synced hs2=0, then go to R_REL.
- R_REL: `uP_handshake_1`=0 for 1 cycle. Then go to R_WAIT for the next byte, or to END after the last reply byte.
- END: wait for synced ack=1, then go to DONE.
- DONE: `done`=1 and `timeout_err`=0 for 1 cycle, then return to IDLE.
- Timeout: the cycle counter resets on every state entry. If TIMEOUT_CYCLES is nonzero and the counter reaches it in W_HS1, W_REL, R_WAIT, R_ACK or END, go to ABORT.
- ABORT: all bus outputs go to 0 that cycle. The next cycle pulses `done`=1 with `timeout_err`=1, then the block returns to IDLE. `reply_packet` keeps the bytes captured so far; the remaining bytes stay 0.
- `req` during `busy` is ignored; there is no queue.
- Asynchronous reset mid-transaction: all bus outputs drop to 0 immediately; no `done` pulse is issued.
- The byte counter is `$clog2(max(CMD_BYTES,REPLY_BYTES))` bits wide (minimum 1). Index comparisons use `CMD_BYTES-1` and `REPLY_BYTES-1`.

## Timing
- Accept to first `uP_start` high: 1 cycle.
- `uP_handshake_2` / `uP_ack` recognition: 2 cycles after the pin edge (synchroniser latency).
- `uP_data_out` and `uP_RW` are stable for at least SETUP_CYCLES before `uP_handshake_1` rises.
- `uP_data_out` and `uP_RW` stay stable until 1 cycle after `uP_handshake_1` falls.
- Read data is sampled SETUP_CYCLES after synced hs2 is seen high; the slave must hold data until it sees hs1 rise.
- Ideal write byte time: SETUP_CYCLES + 2×(slave response + 2) + 1 cycles.
- `done` asserts 1 cycle after synced ack is seen high.
- `done` asserts 1 cycle after ABORT is entered.

## Test plan
- Write PWM period: `cmd_packet` = {00,00,00,64,00+PWM_PERIOD,01}, with a responsive slave model returning reply bytes 64,00,00,00,00,00,00,00. Required: the slave logs 6 bytes in order; `reply_packet[31:0]`=0x00000064; `done` pulses once with `timeout_err`=0.
- Parametrised build CMD_BYTES=2, REPLY_BYTES=3: exactly 2 write handshakes and 3 read handshakes occur; `reply_packet` is 24 bits wide, byte 0 first.
- Slave never raises hs2 on the 3rd write byte, TIMEOUT_CYCLES=50: ABORT occurs 50 cycles after W_HS1 entry; `timeout_err`=1; bus outputs are 0; `reply_packet`=0.
- Slave delays hs2 by 40 cycles on every edge, TIMEOUT_CYCLES=0: the transaction completes correctly, with no abort.
- `req` held high throughout: back-to-back transactions, with exactly 1 IDLE cycle between `done` and the next accept; `req` pulses during `busy` are ignored.
- Reset asserted during R_ACK: `uP_handshake_1`, `uP_start` and `uP_RW` go to 0 without waiting for a clock edge. After release, a new `req` completes a full transaction normally.
